uart_tx_sched: RTL and testbench

//  Shares one UART transmit line among NUM_REQ byte sources. Round-robin arbitration; serializes the granted byte as
//  8N1 (or 8N2) using the one-cycle baud tick from the baud divider. Drives baud_clr so bit timing starts
//  at the start bit, not at a free-running phase. Sits between the per-channel byte producers and the UART pin.

---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/uart_tx_sched.sv | 146 ++++++++++++++
 tb/tb_uart_tx_sched.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
//   state_e    : transmit FSM states
//   BAUD_DIV   : divider ratio for 50 MHz -> 9600 baud
//   DATA_W_DEF : default character width
//   FRAME_LEN  : bit periods in a default 8N1 frame
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  localparam int unsigned BAUD_DIV   = 5208;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned FRAME_LEN  = 1 + DATA_W_DEF + 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i   : request vector
//   ptr_i   : index of the highest-priority requester
//   grant_o : one-hot grant (all zero when no request)
//   idx_o   : index of the granted requester (0 when none)
//   any_o   : at least one request present
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  // Scan from ptr_i upwards with wrap; first requester found wins.
  always_comb begin
    int unsigned cand;
    logic [IDX_W-1:0] cand_idx;
    grant_o  = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o             = 1'b1;
        idx_o             = cand_idx;
        grant_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmit line among NUM_REQ byte
// sources; serializes the granted byte as 8N1/8N2, LSB first.
//   clk, rst  : clock, synchronous active-high reset
//   baud_tick : one-cycle pulse per bit period from the baud divider
//   baud_clr  : holds the divider at 0 while idle so bits align to the start bit
//   req_valid : per-requester byte available
//   req_data  : byte i at [i*DATA_W +: DATA_W]
//   req_ready : one-hot accept (combinational), only in IDLE
//   txd       : serial output, idle high
//   busy      : frame in progress
//   grant_id  : requester owning the current frame
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = 4,
  parameter  int unsigned DATA_W    = DATA_W_DEF,
  parameter  int unsigned STOP_BITS = 1,
  localparam int unsigned IDX_W     = $clog2(NUM_REQ),
  localparam int unsigned CNT_W     = $clog2(DATA_W + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      baud_tick,
  output logic                      baud_clr,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      txd,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_id
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                stop_cnt_q, stop_cnt_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    grant_id_q, grant_id_d;
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;
  logic                baud_clr_q, baud_clr_d;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;
  logic                xfer;
  logic [DATA_W-1:0]   sel_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  // Accept only in IDLE; reset suppresses any handshake.
  assign req_ready = (state_q == ST_IDLE && !rst) ? arb_grant : '0;
  assign xfer      = (state_q == ST_IDLE) && arb_any;
  assign sel_data  = req_data[32'(arb_idx) * DATA_W +: DATA_W];

  // Next-state logic; registered outputs are decoded from the next state so
  // they change on the same edge as the state register.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;

    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          shift_d    = sel_data;
          grant_id_d = arb_idx;
          ptr_d      = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          shift_d = {1'b0, shift_q[DATA_W-1:1]};
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            stop_cnt_d = 1'b0;
            state_d    = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) state_d = ST_IDLE;
          else                                  stop_cnt_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    unique case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
    busy_d     = (state_d != ST_IDLE);
    baud_clr_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      ptr_q      <= '0;
      grant_id_q <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      baud_clr_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      baud_clr_q <= baud_clr_d;
    end
  end

  assign txd      = txd_q;
  assign busy     = busy_q;
  assign baud_clr = baud_clr_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: dut (8N1) and dut2 (8N2), each fed by a divider
// model producing one tick every 4 clocks while baud_clr is low.
module tb_uart_tx_sched;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic        clk, rst, extra_tick;
  logic        tick, tick2, clr, clr2;
  logic [3:0]  valid, valid2, ready, ready2;
  logic [31:0] data, data2;
  logic        txd, txd2, busy, busy2;
  logic [1:0]  gid, gid2;
  logic [1:0]  div_cnt, div_cnt2;

  int   total = 0;
  int   bad   = 0;
  int   viol  = 0;
  int   rdy_cnt [4];
  exp_t q0 [$];
  exp_t q1 [$];

  uart_tx_sched #(.NUM_REQ(4), .DATA_W(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .baud_tick(tick), .baud_clr(clr),
    .req_valid(valid), .req_data(data), .req_ready(ready),
    .txd(txd), .busy(busy), .grant_id(gid));

  uart_tx_sched #(.NUM_REQ(4), .DATA_W(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .baud_tick(tick2), .baud_clr(clr2),
    .req_valid(valid2), .req_data(data2), .req_ready(ready2),
    .txd(txd2), .busy(busy2), .grant_id(gid2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Divider models: counter held at 0 while baud_clr, tick on count 3.
  always @(posedge clk) begin
    if (clr !== 1'b0) div_cnt <= 2'd0;
    else              div_cnt <= div_cnt + 2'd1;
    if (clr2 !== 1'b0) div_cnt2 <= 2'd0;
    else               div_cnt2 <= div_cnt2 + 2'd1;
  end
  assign tick  = ((clr === 1'b0) && (div_cnt == 2'd3)) || extra_tick;
  assign tick2 = (clr2 === 1'b0) && (div_cnt2 == 2'd3);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic f_txd(input int w);  return (w != 0) ? txd2 : txd;   endfunction
  function automatic logic f_busy(input int w); return (w != 0) ? busy2 : busy; endfunction
  function automatic logic f_clr(input int w);  return (w != 0) ? clr2 : clr;   endfunction

  // Handshake sanity and per-requester accept counters.
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      for (int i = 0; i < 4; i++) if (ready[i]) rdy_cnt[i] = rdy_cnt[i] + 1;
      if ($countones(ready) > 1 || (ready & ~valid) != 0 || (ready != 0 && busy)) viol++;
      if ($countones(ready2) > 1 || (ready2 & ~valid2) != 0 || (ready2 != 0 && busy2)) viol++;
    end
  end

  // Receive one frame starting at the current negedge (start bit seen).
  task automatic mon_one(input int w);
    int         nstop;
    int         nbits;
    logic [10:0] bits;
    logic        t;
    logic        tbad;
    logic [1:0]  id;
    exp_t        e;
    nstop = (w != 0) ? 2 : 1;
    nbits = 9 + nstop;
    bits  = '1;
    tbad  = 1'b0;
    id    = (w != 0) ? gid2 : gid;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < 4; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (rst) return;
        t = f_txd(w);
        if (c == 0) bits[b] = t;
        else if (t !== bits[b]) tbad = 1'b1;
        if (f_busy(w) !== 1'b1 || f_clr(w) !== 1'b0) tbad = 1'b1;
      end
    end
    @(negedge clk);
    if (rst) return;
    check($sformatf("idle_gap%0d {txd,busy,clr}", w), {29'd0, f_txd(w), f_busy(w), f_clr(w)}, 32'b101);
    if ((w == 0 && q0.size() == 0) || (w != 0 && q1.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL unexpected_frame%0d: got id %0d data %0h expected no frame", w, id, bits[8:1]);
      return;
    end
    e = (w != 0) ? q1.pop_front() : q0.pop_front();
    check($sformatf("start_bit%0d", w), {31'd0, bits[0]}, 32'd0);
    check($sformatf("frame_data%0d", w), {24'd0, bits[8:1]}, {24'd0, e.data});
    check($sformatf("grant_id%0d", w), {30'd0, id}, {30'd0, e.id});
    if (w != 0) check("stop_bits1", {30'd0, bits[10:9]}, 32'b11);
    else        check("stop_bits0", {31'd0, bits[9]}, 32'b1);
    check($sformatf("bit_timing%0d", w), {31'd0, tbad}, 32'd0);
  endtask

  initial begin : mon0
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) mon_one(0);
    end
  end

  initial begin : mon1
    forever begin
      @(negedge clk);
      if (!rst && txd2 === 1'b0) mon_one(1);
    end
  end

  // Offer one byte, wait for the accept, then drop valid and scramble data.
  task automatic send(input int idx, input logic [7:0] d, input bit push);
    bit got;
    exp_t e;
    got = 1'b0;
    data[idx*8 +: 8] = d;
    valid[idx] = 1'b1;
    if (push) begin
      e.id = 2'(idx);
      e.data = d;
      q0.push_back(e);
    end
    for (int n = 0; n < 300; n++) begin
      #1;
      if (ready[idx]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("ready_seen", {31'd0, got}, 32'd1);
    check("arb_cycle {busy,clr}", {30'd0, busy, clr}, 32'b01);
    @(negedge clk);
    valid[idx] = 1'b0;
    data[idx*8 +: 8] = 8'hFF;
  endtask

  task automatic wait_idle(input int w);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (!f_busy(w)) begin
        done = 1'b1;
        break;
      end
    end
    check($sformatf("idle_reached%0d", w), {31'd0, done}, 32'd1);
  endtask

  initial begin : stim
    int   snap [4];
    int   acc;
    bit   saw_busy;
    exp_t e;
    rst = 1'b1;
    extra_tick = 1'b0;
    valid = 4'hF;
    valid2 = 4'h0;
    data = '0;
    data2 = '0;
    repeat (3) @(negedge clk);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_clr", {31'd0, clr}, 32'd1);
    check("rst_ready", {28'd0, ready}, 32'd0);
    check("rst_gid", {30'd0, gid}, 32'd0);
    check("rst_txd2", {31'd0, txd2}, 32'd1);
    valid = 4'h0;
    rst = 1'b0;

    // Single byte 0xA5 from requester 0.
    for (int i = 0; i < 4; i++) snap[i] = rdy_cnt[i];
    send(0, 8'hA5, 1'b1);
    wait_idle(0);
    check("t1_ready_pulses", 32'(rdy_cnt[0] - snap[0]), 32'd1);

    // All requesters valid continuously from pointer 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data[i*8 +: 8] = 8'h10 + 8'(i);
      snap[i] = rdy_cnt[i];
    end
    for (int k = 0; k < 5; k++) begin
      e.id = 2'(k % 4);
      e.data = 8'h10 + 8'(k % 4);
      q0.push_back(e);
    end
    valid = 4'hF;
    acc = 0;
    for (int n = 0; n < 1500 && acc < 5; n++) begin
      #1;
      if ((ready & valid) != 0) acc++;
      @(negedge clk);
    end
    valid = 4'h0;
    check("t2_accepts", 32'(acc), 32'd5);
    wait_idle(0);
    check("t2_ready0", 32'(rdy_cnt[0] - snap[0]), 32'd2);
    check("t2_ready1", 32'(rdy_cnt[1] - snap[1]), 32'd1);
    check("t2_ready2", 32'(rdy_cnt[2] - snap[2]), 32'd1);
    check("t2_ready3", 32'(rdy_cnt[3] - snap[3]), 32'd1);

    // Reset during DATA bit 3 abandons the frame and clears the pointer.
    send(1, 8'h3C, 1'b0);
    repeat (17) @(negedge clk);
    check("t3_busy_mid", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t3_txd", {31'd0, txd}, 32'd1);
    check("t3_busy", {31'd0, busy}, 32'd0);
    check("t3_clr", {31'd0, clr}, 32'd1);
    check("t3_gid", {30'd0, gid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(2, 8'h5A, 1'b1);
    wait_idle(0);

    // Ticks while idle are ignored.
    for (int k = 0; k < 4; k++) begin
      extra_tick = 1'b1;
      @(negedge clk);
      extra_tick = 1'b0;
      check("t4_idle_txd", {31'd0, txd}, 32'd1);
      check("t4_idle_busy", {31'd0, busy}, 32'd0);
      check("t4_idle_clr", {31'd0, clr}, 32'd1);
      @(negedge clk);
    end

    // Valid raised and dropped while busy produces no frame.
    snap[1] = rdy_cnt[1];
    send(0, 8'h81, 1'b1);
    repeat (6) @(negedge clk);
    valid[1] = 1'b1;
    data[15:8] = 8'h77;
    repeat (10) @(negedge clk);
    valid[1] = 1'b0;
    wait_idle(0);
    saw_busy = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    check("t4_no_frame", {31'd0, saw_busy}, 32'd0);
    check("t4_ready1", 32'(rdy_cnt[1] - snap[1]), 32'd0);

    // Two stop bits, back-to-back 0x00 frames on dut2.
    e.id = 2'd0; e.data = 8'h00; q1.push_back(e);
    e.id = 2'd1; e.data = 8'h00; q1.push_back(e);
    valid2 = 4'b0011;
    acc = 0;
    for (int n = 0; n < 600 && acc < 2; n++) begin
      #1;
      if ((ready2 & valid2) != 0) acc++;
      @(negedge clk);
    end
    valid2 = 4'h0;
    check("t5_accepts", 32'(acc), 32'd2);
    wait_idle(1);

    repeat (8) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("handshake_violations", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
